// File: rtl/spi_rom_arbiter_if.sv
// rtl/spi_rom_arbiter_if.sv - requester, invalidate and SPI ROM signals of spi_rom_arbiter
interface spi_rom_arbiter_if;
   logic        i_req;
   logic [24:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;

   logic        d_req;
   logic [24:0] d_addr;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic        inv;

   logic [24:0] rom_addr;
   logic        rom_addr_valid;
   logic        rom_addr_ready;
   logic [31:0] rom_data;
   logic        rom_data_valid;

   // master: the arbiter itself; slave: requesters plus the SPI ROM reader
   modport master (
      input  i_req, i_addr, d_req, d_addr, inv,
      input  rom_addr_ready, rom_data, rom_data_valid,
      output i_gnt, i_rvalid, i_rdata, i_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output rom_addr, rom_addr_valid
   );

   modport slave (
      output i_req, i_addr, d_req, d_addr, inv,
      output rom_addr_ready, rom_data, rom_data_valid,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  rom_addr, rom_addr_valid
   );
endinterface

// File: rtl/spi_rom_arbiter.sv
// rtl/spi_rom_arbiter.sv - shares one SPI ROM reader between fetch (i) and data (d) ports
// One read in flight at a time, with a one-entry hit buffer in front of the ROM.
module spi_rom_arbiter #(
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 255,
   parameter int HIT_BUF_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   spi_rom_arbiter_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(MAX_STREAK + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HIT,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic          r_owner;
   logic [24:0]   r_addr;
   logic [SW-1:0] r_streak;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_data;
   logic          r_err;

   logic          r_buf_valid;
   logic [24:0]   r_buf_addr;
   logic [31:0]   r_buf_data;

   logic          w_streak_full;
   logic          w_pick_d;
   logic          w_pick_i;
   logic          w_grant;
   logic [24:0]   w_req_addr;
   logic          w_lookup_hit;
   logic          w_cnt_last;

   logic          w_i_gnt;
   logic          w_d_gnt;
   logic          w_rvalid;
   logic [31:0]   w_rdata;
   logic          w_err;
   logic [24:0]   w_rom_addr;
   logic          w_rom_addr_valid;

   assign w_streak_full = (r_streak == SW'(MAX_STREAK));
   assign w_pick_d      = bus.d_req & (~bus.i_req | w_streak_full);
   assign w_pick_i      = bus.i_req & ~w_pick_d;
   assign w_grant       = w_pick_i | w_pick_d;
   assign w_req_addr    = w_pick_d ? bus.d_addr : bus.i_addr;

   // An invalidate in the lookup cycle already counts as a miss
   assign w_lookup_hit  = (HIT_BUF_EN != 0) && r_buf_valid && !bus.inv &&
                          (w_req_addr == r_buf_addr);

   // Last WAIT cycle: the response then lands exactly TIMEOUT cycles after WAIT entry
   assign w_cnt_last    = (r_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      w_next           = r_state;
      w_i_gnt          = 1'b0;
      w_d_gnt          = 1'b0;
      w_rvalid         = 1'b0;
      w_rdata          = '0;
      w_err            = 1'b0;
      w_rom_addr       = '0;
      w_rom_addr_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant && !rst) begin
               w_i_gnt = w_pick_i;
               w_d_gnt = w_pick_d;
               w_next  = w_lookup_hit ? ST_HIT : ST_ISSUE;
            end
         end
         ST_HIT: begin
            w_rvalid = 1'b1;
            w_rdata  = r_buf_data;
            w_next   = ST_IDLE;
         end
         ST_ISSUE: begin
            w_rom_addr_valid = 1'b1;
            w_rom_addr       = r_addr;
            if (bus.rom_addr_ready) begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.rom_data_valid || w_cnt_last) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_rvalid = 1'b1;
            w_rdata  = r_err ? 32'h0 : r_data;
            w_err    = r_err;
            w_next   = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign bus.i_gnt          = w_i_gnt;
   assign bus.d_gnt          = w_d_gnt;
   assign bus.i_rvalid       = w_rvalid & ~r_owner;
   assign bus.d_rvalid       = w_rvalid & r_owner;
   assign bus.i_rdata        = r_owner ? 32'h0 : w_rdata;
   assign bus.d_rdata        = r_owner ? w_rdata : 32'h0;
   assign bus.i_err          = w_err & ~r_owner;
   assign bus.d_err          = w_err & r_owner;
   assign bus.rom_addr       = w_rom_addr;
   assign bus.rom_addr_valid = w_rom_addr_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= 1'b0;
         r_addr      <= '0;
         r_streak    <= '0;
         r_cnt       <= '0;
         r_data      <= '0;
         r_err       <= 1'b0;
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
      end else begin
         r_state <= w_next;

         if (w_i_gnt || w_d_gnt) begin
            r_owner <= w_d_gnt;
            r_addr  <= w_req_addr;
         end

         if (!bus.d_req || w_d_gnt) begin
            r_streak <= '0;
         end else if (w_i_gnt && !w_streak_full) begin
            r_streak <= r_streak + 1'b1;
         end

         r_cnt <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;

         // Data arriving on the final WAIT cycle still beats the timeout
         if (r_state == ST_WAIT) begin
            if (bus.rom_data_valid) begin
               r_data <= bus.rom_data;
               r_err  <= 1'b0;
            end else if (w_cnt_last) begin
               r_data <= '0;
               r_err  <= 1'b1;
            end
         end

         if (bus.inv) begin
            r_buf_valid <= 1'b0;
         end else if ((HIT_BUF_EN != 0) && (r_state == ST_RESP) && !r_err) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_addr;
            r_buf_data  <= r_data;
         end
      end
   end
endmodule

// File: tb/tb_spi_rom_arbiter.sv
// tb/tb_spi_rom_arbiter.sv - scoreboard bench for spi_rom_arbiter
module tb_spi_rom_arbiter;
   localparam int MAX_STREAK = 4;
   localparam int TIMEOUT    = 255;

   typedef struct {
      logic        port_d;
      logic [24:0] addr;
      logic [31:0] data;
      logic        err;
      logic        hit;
      int          gcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_rom_arbiter_if bus ();

   spi_rom_arbiter #(
      .MAX_STREAK (MAX_STREAK),
      .TIMEOUT    (TIMEOUT),
      .HIT_BUF_EN (1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int rom_lat     = 3;
   int rdy_delay   = 0;
   bit inv_on_fill = 1'b0;
   int last_hs     = 0;
   int rom_reqs    = 0;
   int av_cycles   = 0;
   int rv_count    = 0;

   logic [24:0] i_q[$];
   logic [24:0] d_q[$];
   exp_t        sb[$];
   logic        g_log[$];

   int          m_streak;
   logic        m_buf_valid;
   logic [24:0] m_buf_addr;
   logic [31:0] m_buf_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [24:0] a);
      if (a == 25'h100) return 32'h0123_4567;
      return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
   endfunction

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while ((i_q.size() != 0 || d_q.size() != 0 || sb.size() != 0) && n < 3000);
      chk({tag, "_idle_bound"}, (n < 3000), 1);
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Requesters: hold req/addr until the head of each queue is granted
   initial begin
      bus.i_req  = 1'b0;
      bus.i_addr = '0;
      bus.d_req  = 1'b0;
      bus.d_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.i_req  = (i_q.size() > 0);
         bus.i_addr = (i_q.size() > 0) ? i_q[0] : 25'h0;
         bus.d_req  = (d_q.size() > 0);
         bus.d_addr = (d_q.size() > 0) ? d_q[0] : 25'h0;
      end
   end

   // SPI ROM reader model; rom_lat==0 means it never answers
   initial begin
      int   rdy_cnt;
      int   pend;
      logic [24:0] pend_addr;
      bit   inv_next;
      rdy_cnt   = 0;
      pend      = 0;
      pend_addr = '0;
      inv_next  = 1'b0;
      bus.rom_addr_ready = 1'b0;
      bus.rom_data       = '0;
      bus.rom_data_valid = 1'b0;
      bus.inv            = 1'b0;
      forever begin
         @(negedge clk);
         bus.rom_data_valid = 1'b0;
         bus.inv  = inv_next;
         inv_next = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.rom_data       = rom_word(pend_addr);
               bus.rom_data_valid = 1'b1;
               if (inv_on_fill) inv_next = 1'b1;
            end
         end
         if (bus.rom_addr_valid) av_cycles++;
         if (rst) begin
            pend               = 0;
            rdy_cnt            = 0;
            bus.rom_addr_ready = 1'b0;
         end else if (bus.rom_addr_valid) begin
            if (rdy_cnt < rdy_delay) begin
               bus.rom_addr_ready = 1'b0;
               rdy_cnt++;
            end else begin
               bus.rom_addr_ready = 1'b1;
               rdy_cnt   = 0;
               pend_addr = bus.rom_addr;
               pend      = rom_lat;
               last_hs   = cyc;
               rom_reqs++;
            end
         end else begin
            bus.rom_addr_ready = 1'b0;
         end
      end
   end

   // Grant/response monitor with arbitration and hit-buffer model
   initial begin
      exp_t        e;
      logic        exp_d;
      logic [24:0] a;
      logic        gr;
      m_streak    = 0;
      m_buf_valid = 1'b0;
      m_buf_addr  = '0;
      m_buf_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            m_streak    = 0;
            m_buf_valid = 1'b0;
            sb.delete();
            continue;
         end
         gr    = bus.i_gnt | bus.d_gnt;
         exp_d = bus.d_req && (!bus.i_req || m_streak == MAX_STREAK);
         if (gr) begin
            chk("gnt_port", {bus.d_gnt, bus.i_gnt}, exp_d ? 2'b10 : 2'b01);
            a        = exp_d ? bus.d_addr : bus.i_addr;
            e.port_d = exp_d;
            e.addr   = a;
            e.gcyc   = cyc;
            e.hit    = m_buf_valid && !bus.inv && (a == m_buf_addr);
            if (e.hit) begin
               e.data = m_buf_data;
               e.err  = 1'b0;
            end else if (rom_lat >= 1 && rom_lat <= TIMEOUT) begin
               e.data = rom_word(a);
               e.err  = 1'b0;
            end else begin
               e.data = 32'h0;
               e.err  = 1'b1;
            end
            sb.push_back(e);
            g_log.push_back(exp_d);
            if (bus.d_gnt && d_q.size() > 0) void'(d_q.pop_front());
            if (bus.i_gnt && i_q.size() > 0) void'(i_q.pop_front());
         end
         if (!bus.d_req) m_streak = 0;
         else if (gr && exp_d) m_streak = 0;
         else if (gr && m_streak < MAX_STREAK) m_streak++;

         if (bus.i_rvalid || bus.d_rvalid) begin
            rv_count++;
            chk("rvalid_onehot", bus.i_rvalid & bus.d_rvalid, 0);
            if (sb.size() == 0) begin
               chk("rvalid_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rsp_port", bus.d_rvalid, e.port_d);
               chk("rsp_data", e.port_d ? bus.d_rdata : bus.i_rdata, e.data);
               chk("rsp_err", e.port_d ? bus.d_err : bus.i_err, e.err);
               if (e.hit) chk("hit_latency", cyc - e.gcyc, 1);
               else if (e.err) chk("timeout_latency", cyc - last_hs, TIMEOUT + 1);
               else chk("rom_latency", cyc - last_hs, rom_lat + 1);
               if (!e.hit && !e.err && !bus.inv) begin
                  m_buf_valid = 1'b1;
                  m_buf_addr  = e.addr;
                  m_buf_data  = e.data;
               end
            end
         end
         if (bus.inv) m_buf_valid = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int vc;
      int gl;
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_ctrl", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid,
                       bus.i_err, bus.d_err, bus.rom_addr_valid}, 0);
      chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Miss served by ROM with a slow addr_ready
      rom_lat   = 3;
      rdy_delay = 2;
      base      = rom_reqs;
      i_q.push_back(25'h000100);
      wait_idle("t1");
      chk("t1_rom_reqs", rom_reqs - base, 1);

      // Same address on d hits the buffer with no ROM traffic
      base = rom_reqs;
      vc   = av_cycles;
      d_q.push_back(25'h000100);
      wait_idle("t2");
      chk("t2_rom_reqs", rom_reqs - base, 0);
      chk("t2_addr_valid_cycles", av_cycles - vc, 0);

      // Both ports saturated: four fetch grants then one data grant
      rdy_delay = 0;
      rom_lat   = 2;
      gl        = g_log.size();
      for (int k = 0; k < 10; k++) begin
         i_q.push_back(25'h1000 + 25'(k));
         d_q.push_back(25'h2000 + 25'(k));
      end
      wait_idle("t3");
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("t3_grant%0d", k), g_log[gl + k], ((k % 5) == 4));
      end

      // No completion at all: error response after TIMEOUT cycles
      rom_lat = 0;
      i_q.push_back(25'h000300);
      wait_idle("t4");

      // Late completion after a timeout is dropped; the retry goes to ROM
      rom_lat = TIMEOUT + 20;
      i_q.push_back(25'h000400);
      wait_idle("t5a");
      repeat (40) @(posedge clk);
      #1;
      rom_lat = 3;
      base    = rom_reqs;
      i_q.push_back(25'h000400);
      wait_idle("t5b");
      chk("t5_rom_reqs", rom_reqs - base, 1);

      // Completion on the very last WAIT cycle is still a good response
      rom_lat = TIMEOUT;
      d_q.push_back(25'h000500);
      wait_idle("t5c");

      // Invalidate coincident with the fill leaves the buffer empty
      rom_lat     = 3;
      inv_on_fill = 1'b1;
      i_q.push_back(25'h000600);
      wait_idle("t6a");
      inv_on_fill = 1'b0;
      base        = rom_reqs;
      d_q.push_back(25'h000600);
      wait_idle("t6b");
      chk("t6_rom_reqs", rom_reqs - base, 1);

      // Reset while waiting on the ROM drops the transaction silently
      rom_lat = 0;
      base    = rom_reqs;
      i_q.push_back(25'h000800);
      n = 0;
      while (rom_reqs == base && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("t7_reached_wait", rom_reqs - base, 1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("t7_rst_ctrl", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid,
                          bus.i_err, bus.d_err, bus.rom_addr_valid}, 0);
      chk("t7_rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vc  = rv_count;
      repeat (300) @(posedge clk);
      #1;
      chk("t7_no_rvalid", rv_count - vc, 0);

      // Buffer was cleared by reset: the earlier hit address misses now
      rom_lat = 3;
      base    = rom_reqs;
      i_q.push_back(25'h000100);
      wait_idle("t8");
      chk("t8_rom_reqs", rom_reqs - base, 1);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
